// File: rtl/dp_ram_be_if.sv
// Bus bundle for dp_ram_be: sweep control plus two symmetric byte-enabled access ports.
interface dp_ram_be_if #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 32
);
  localparam int BE_SIZE = DATA_SIZE / 8;

  logic                 clear;
  logic                 busy;
  logic                 en_A;
  logic                 w_e_A;
  logic [BE_SIZE-1:0]   be_A;
  logic [ADDR_SIZE-1:0] addr_A;
  logic [DATA_SIZE-1:0] data_in_A;
  logic [DATA_SIZE-1:0] data_out_A;
  logic                 valid_A;
  logic                 en_B;
  logic                 w_e_B;
  logic [BE_SIZE-1:0]   be_B;
  logic [ADDR_SIZE-1:0] addr_B;
  logic [DATA_SIZE-1:0] data_in_B;
  logic [DATA_SIZE-1:0] data_out_B;
  logic                 valid_B;

  modport master (
    output clear, en_A, w_e_A, be_A, addr_A, data_in_A,
    output en_B, w_e_B, be_B, addr_B, data_in_B,
    input  busy, data_out_A, valid_A, data_out_B, valid_B
  );

  modport slave (
    input  clear, en_A, w_e_A, be_A, addr_A, data_in_A,
    input  en_B, w_e_B, be_B, addr_B, data_in_B,
    output busy, data_out_A, valid_A, data_out_B, valid_B
  );
endinterface

// File: rtl/dp_ram_be.sv
// True dual-port byte-enabled RAM with optional output register and a zeroing sweep
// sequencer that owns the array while busy.
module dp_ram_be #(
  parameter int ADDR_SIZE      = 16,
  parameter int DATA_SIZE      = 32,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic       clk,
  input  logic       nRST,
  dp_ram_be_if.slave bus
);
  localparam int BE_SIZE = DATA_SIZE / 8;
  localparam int DEPTH   = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = {ADDR_SIZE{1'b1}};
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;
  // Resetting straight into CLEAR keeps busy high through reset and starts the sweep on the first edge.
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] sweep_q, sweep_d;
  logic                 busy_s;

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [BE_SIZE-1:0]   wbe_a_s, wbe_b_s;
  logic [1:0]           rd_s;
  logic [DATA_SIZE-1:0] rword_s  [2];
  logic [DATA_SIZE-1:0] data1_q  [2];
  logic [DATA_SIZE-1:0] data1_d  [2];
  logic [DATA_SIZE-1:0] data2_q  [2];
  logic [DATA_SIZE-1:0] data2_d  [2];
  logic [1:0]           valid1_q, valid1_d, valid2_q, valid2_d;

  assign busy_s = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        sweep_d = sweep_q + ADDR_ONE;
        if (sweep_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = IDLE;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= RESET_STATE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    wbe_a_s    = '0;
    wbe_b_s    = '0;
    rd_s       = 2'b00;
    rword_s[0] = mem[bus.addr_A];
    rword_s[1] = mem[bus.addr_B];
    if (!busy_s) begin
      rd_s[0] = bus.en_A & ~bus.w_e_A;
      rd_s[1] = bus.en_B & ~bus.w_e_B;
      if (bus.en_A & bus.w_e_A) begin
        wbe_a_s = bus.be_A;
      end else begin
        wbe_a_s = '0;
      end
      if (bus.en_B & bus.w_e_B) begin
        wbe_b_s = bus.be_B;
      end else begin
        wbe_b_s = '0;
      end
      // Same-address collision: port A owns every byte it enables.
      if (bus.addr_A == bus.addr_B) begin
        wbe_b_s = wbe_b_s & ~wbe_a_s;
      end else begin
        wbe_b_s = wbe_b_s;
      end
    end else begin
      rd_s = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (busy_s) begin
      mem[sweep_q] <= '0;
    end else begin
      for (int i = 0; i < BE_SIZE; i++) begin
        if (wbe_a_s[i]) mem[bus.addr_A][8*i +: 8] <= bus.data_in_A[8*i +: 8];
        if (wbe_b_s[i]) mem[bus.addr_B][8*i +: 8] <= bus.data_in_B[8*i +: 8];
      end
    end
  end

  // Data registers only load alongside a valid, so outputs hold between reads.
  always_comb begin
    valid1_d   = rd_s;
    valid2_d   = valid1_q;
    data1_d[0] = data1_q[0];
    data1_d[1] = data1_q[1];
    data2_d[0] = data2_q[0];
    data2_d[1] = data2_q[1];
    for (int p = 0; p < 2; p++) begin
      if (rd_s[p]) begin
        data1_d[p] = rword_s[p];
      end else begin
        data1_d[p] = data1_q[p];
      end
      if (valid1_q[p]) begin
        data2_d[p] = data1_q[p];
      end else begin
        data2_d[p] = data2_q[p];
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      valid1_q   <= 2'b00;
      valid2_q   <= 2'b00;
      data1_q[0] <= '0;
      data1_q[1] <= '0;
      data2_q[0] <= '0;
      data2_q[1] <= '0;
    end else begin
      valid1_q   <= valid1_d;
      valid2_q   <= valid2_d;
      data1_q[0] <= data1_d[0];
      data1_q[1] <= data1_d[1];
      data2_q[0] <= data2_d[0];
      data2_q[1] <= data2_d[1];
    end
  end

  assign bus.busy       = busy_s;
  assign bus.valid_A    = (OUT_REG != 0) ? valid2_q[0] : valid1_q[0];
  assign bus.valid_B    = (OUT_REG != 0) ? valid2_q[1] : valid1_q[1];
  assign bus.data_out_A = (OUT_REG != 0) ? data2_q[0]  : data1_q[0];
  assign bus.data_out_B = (OUT_REG != 0) ? data2_q[1]  : data1_q[1];
endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: two instances (latency 1 and 2) share one stimulus stream and
// are checked against a word-array reference model plus a table of directed vectors.
module tb_dp_ram_be;
  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  dp_ram_be_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) bus0 ();
  dp_ram_be_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) bus1 ();

  assign bus1.clear     = bus0.clear;
  assign bus1.en_A      = bus0.en_A;
  assign bus1.w_e_A     = bus0.w_e_A;
  assign bus1.be_A      = bus0.be_A;
  assign bus1.addr_A    = bus0.addr_A;
  assign bus1.data_in_A = bus0.data_in_A;
  assign bus1.en_B      = bus0.en_B;
  assign bus1.w_e_B     = bus0.w_e_B;
  assign bus1.be_B      = bus0.be_B;
  assign bus1.addr_B    = bus0.addr_B;
  assign bus1.data_in_B = bus0.data_in_B;

  dp_ram_be #(.ADDR_SIZE(4), .DATA_SIZE(32), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .nRST(nRST), .bus(bus0.slave));
  dp_ram_be #(.ADDR_SIZE(4), .DATA_SIZE(32), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .nRST(nRST), .bus(bus1.slave));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: word array, remaining sweep cycles, per-port read history.
  logic [31:0] mm [16];
  int          bcnt;
  logic        hv0_a, hv0_b, hv1_a, hv1_b;
  logic [31:0] hd0_a, hd0_b, hd1_a, hd1_b;
  logic        ev1_a, ev1_b, ev2_a, ev2_b;
  logic [31:0] ed1_a, ed1_b, ed2_a, ed2_b;

  typedef struct {
    logic        a_en, a_we;
    logic [3:0]  a_be, a_addr;
    logic [31:0] a_din;
    logic        b_en, b_we;
    logic [3:0]  b_be, b_addr;
    logic [31:0] b_din;
    logic        chk_a;
    logic [31:0] exp_a;
    logic        chk_b;
    logic [31:0] exp_b;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
    return (old & ~m) | (nw & m);
  endfunction

  task automatic drive(input logic ae, input logic aw, input logic [3:0] abe, input logic [3:0] aad,
                       input logic [31:0] ad, input logic ben, input logic bw, input logic [3:0] bbe,
                       input logic [3:0] bad, input logic [31:0] bd, input logic clr);
    bus0.en_A = ae; bus0.w_e_A = aw; bus0.be_A = abe; bus0.addr_A = aad; bus0.data_in_A = ad;
    bus0.en_B = ben; bus0.w_e_B = bw; bus0.be_B = bbe; bus0.addr_B = bad; bus0.data_in_B = bd;
    bus0.clear = clr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b0);
  endtask

  task automatic check_outputs(input logic exp_busy);
    chk("busy_L1", bus0.busy, exp_busy);
    chk("busy_L2", bus1.busy, exp_busy);
    chk("valid_A_L1", bus0.valid_A, ev1_a);
    chk("valid_B_L1", bus0.valid_B, ev1_b);
    chk("data_out_A_L1", bus0.data_out_A, ed1_a);
    chk("data_out_B_L1", bus0.data_out_B, ed1_b);
    chk("valid_A_L2", bus1.valid_A, ev2_a);
    chk("valid_B_L2", bus1.valid_B, ev2_b);
    chk("data_out_A_L2", bus1.data_out_A, ed2_a);
    chk("data_out_B_L2", bus1.data_out_B, ed2_b);
  endtask

  task automatic reset_model();
    hv0_a = 1'b0; hv0_b = 1'b0; hv1_a = 1'b0; hv1_b = 1'b0;
    hd0_a = 32'd0; hd0_b = 32'd0; hd1_a = 32'd0; hd1_b = 32'd0;
    ev1_a = 1'b0; ev1_b = 1'b0; ev2_a = 1'b0; ev2_b = 1'b0;
    ed1_a = 32'd0; ed1_b = 32'd0; ed2_a = 32'd0; ed2_b = 32'd0;
  endtask

  // One clock: apply the model to the inputs now on the bus, advance, then compare.
  task automatic step();
    logic rd_a, rd_b;
    logic [31:0] rdat_a, rdat_b;
    rd_a = 1'b0; rd_b = 1'b0; rdat_a = 32'd0; rdat_b = 32'd0;
    if (bcnt > 0) begin
      mm[4'(16 - bcnt)] = 32'd0;
      bcnt = bcnt - 1;
    end else begin
      rd_a = bus0.en_A && !bus0.w_e_A;
      rd_b = bus0.en_B && !bus0.w_e_B;
      rdat_a = mm[bus0.addr_A];
      rdat_b = mm[bus0.addr_B];
      if (bus0.en_B && bus0.w_e_B) mm[bus0.addr_B] = merge(mm[bus0.addr_B], bus0.data_in_B, bus0.be_B);
      if (bus0.en_A && bus0.w_e_A) mm[bus0.addr_A] = merge(mm[bus0.addr_A], bus0.data_in_A, bus0.be_A);
      if (bus0.clear) bcnt = 16;
    end
    @(posedge clk);
    #1;
    hv1_a = hv0_a; hd1_a = hd0_a; hv1_b = hv0_b; hd1_b = hd0_b;
    hv0_a = rd_a;  hd0_a = rdat_a; hv0_b = rd_b;  hd0_b = rdat_b;
    ev1_a = hv0_a; if (hv0_a) ed1_a = hd0_a;
    ev1_b = hv0_b; if (hv0_b) ed1_b = hd0_b;
    ev2_a = hv1_a; if (hv1_a) ed2_a = hd1_a;
    ev2_b = hv1_b; if (hv1_b) ed2_b = hd1_b;
    check_outputs(bcnt > 0);
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    #1;
    reset_model();
    check_outputs(1'b1);
    repeat (2) @(posedge clk);
    #1;
    nRST = 1'b1;
    bcnt = 16;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 4'd0, 32'd245,       1'b0, 1'b0, 4'h0, 4'd0, 32'd0,       1'b0, 32'd0,         1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b0, 4'h0, 4'd0, 32'd0,         1'b1, 1'b0, 4'h0, 4'd0, 32'd0,       1'b0, 32'd0,         1'b1, 32'd245};
    tbl[2]  = '{1'b1, 1'b1, 4'hF, 4'd3, 32'h11223344,  1'b0, 1'b0, 4'h0, 4'd0, 32'd0,       1'b0, 32'd0,         1'b0, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 4'h5, 4'd3, 32'hAABBCCDD,  1'b0, 1'b0, 4'h0, 4'd0, 32'd0,       1'b0, 32'd0,         1'b0, 32'd0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 4'd0, 32'd0,         1'b1, 1'b0, 4'h0, 4'd3, 32'd0,       1'b0, 32'd0,         1'b1, 32'h11BB33DD};
    tbl[5]  = '{1'b1, 1'b1, 4'h3, 4'd5, 32'hAAAAAAAA,  1'b1, 1'b1, 4'h6, 4'd5, 32'hBBBBBBBB, 1'b0, 32'd0,        1'b0, 32'd0};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 4'd0, 32'd0,         1'b1, 1'b0, 4'h0, 4'd5, 32'd0,       1'b0, 32'd0,         1'b1, 32'h00BBAAAA};
    tbl[7]  = '{1'b1, 1'b1, 4'hF, 4'd2, 32'd420,       1'b0, 1'b0, 4'h0, 4'd0, 32'd0,       1'b0, 32'd0,         1'b0, 32'd0};
    tbl[8]  = '{1'b1, 1'b1, 4'hF, 4'd2, 32'd7,         1'b1, 1'b0, 4'h0, 4'd2, 32'd0,       1'b0, 32'd0,         1'b1, 32'd420};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 4'd0, 32'd0,         1'b1, 1'b0, 4'h0, 4'd2, 32'd0,       1'b0, 32'd0,         1'b1, 32'd7};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 4'd5, 32'd0,         1'b1, 1'b0, 4'h0, 4'd3, 32'd0,       1'b1, 32'h00BBAAAA,  1'b1, 32'h11BB33DD};

    nRST = 1'b1;
    bcnt = 0;
    idle();
    #2;
    do_reset();

    // Power-on sweep length, then every word reads back as zero.
    n = 0;
    while (bus0.busy && n < 40) begin step(); n++; end
    chk("busy_cycles_after_reset", n, 16);
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 1'b0, 4'h0, 4'(a), 32'd0, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b0);
      step();
      chk("swept_word_zero", bus0.data_out_A, 32'd0);
      chk("swept_read_valid", bus0.valid_A, 1'b1);
    end
    idle(); step(); step();

    // Directed vectors: result after one edge on the latency-1 part, two on the latency-2 part.
    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].a_en, tbl[k].a_we, tbl[k].a_be, tbl[k].a_addr, tbl[k].a_din,
            tbl[k].b_en, tbl[k].b_we, tbl[k].b_be, tbl[k].b_addr, tbl[k].b_din, 1'b0);
      step();
      chk("tbl_valid_A_L1", bus0.valid_A, tbl[k].chk_a);
      chk("tbl_valid_B_L1", bus0.valid_B, tbl[k].chk_b);
      if (tbl[k].chk_a) chk("tbl_data_A_L1", bus0.data_out_A, tbl[k].exp_a);
      if (tbl[k].chk_b) chk("tbl_data_B_L1", bus0.data_out_B, tbl[k].exp_b);
      idle();
      step();
      chk("tbl_valid_A_L2", bus1.valid_A, tbl[k].chk_a);
      chk("tbl_valid_B_L2", bus1.valid_B, tbl[k].chk_b);
      if (tbl[k].chk_a) chk("tbl_data_A_L2", bus1.data_out_A, tbl[k].exp_a);
      if (tbl[k].chk_b) chk("tbl_data_B_L2", bus1.data_out_B, tbl[k].exp_b);
    end

    // Random traffic on both ports with occasional clear pulses.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 32'($urandom()),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 32'($urandom()), ($urandom_range(0, 39) == 0));
      step();
    end
    idle();
    n = 0;
    while (bus0.busy && n < 40) begin step(); n++; end
    chk("busy_drained_after_random", bus0.busy, 1'b0);
    step(); step();

    // Reset in the middle of a sweep started by clear.
    drive(1'b1, 1'b1, 4'hF, 4'd9, 32'h5A5A1234, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b0);
    step();
    drive(1'b1, 1'b0, 4'h0, 4'd9, 32'd0, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b1);
    step();
    idle();
    n = 0;
    while (bcnt > 10 && n < 40) begin step(); n++; end
    chk("pre_reset_data_A_L1", bus0.data_out_A, 32'h5A5A1234);
    chk("pre_reset_data_A_L2", bus1.data_out_A, 32'h5A5A1234);
    do_reset();
    n = 0;
    while (bus0.busy && n < 40) begin
      if (n == 0)
        drive(1'b1, 1'b1, 4'hF, 4'd15, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b0);
      else if (n == 15)
        drive(1'b1, 1'b1, 4'hF, 4'd0, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b0);
      else
        idle();
      step();
      n++;
    end
    chk("busy_cycles_after_mid_reset", n, 16);
    drive(1'b1, 1'b0, 4'h0, 4'd0, 32'd0, 1'b1, 1'b0, 4'h0, 4'd15, 32'd0, 1'b0);
    step();
    chk("busy_write_dropped_addr0", bus0.data_out_A, 32'd0);
    chk("busy_write_dropped_addr15", bus0.data_out_B, 32'd0);
    drive(1'b1, 1'b0, 4'h0, 4'd9, 32'd0, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0, 1'b0);
    step();
    chk("resweep_addr9_zero", bus0.data_out_A, 32'd0);
    idle(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dp_ram_be.md
Name: dp_ram_be

Overview:
Parametrised true dual-port synchronous RAM. It succeeds the single-write-port RAM: both ports can now read and write, writes are byte-enabled, and an optional output register stage is available. A built-in clear sequencer zeroes the array after reset or on request. It is the shared frame and line storage for the video pipeline blocks.

Parameters:
ADDR_SIZE, 16, address width; depth DEPTH = 2**ADDR_SIZE words.
DATA_SIZE, 32, word width; must be a multiple of 8.
BE_SIZE, DATA_SIZE/8, byte-enable width (derived, not overridden).
OUT_REG, 0, 0 gives read latency 1; 1 adds an output register stage, giving latency 2.
CLEAR_ON_RESET, 1, 1 starts a zeroing sweep automatically when nRST releases.

Ports:
clk  in  1  system clock, rising edge.
nRST  in  1  reset, asynchronous, active-low.
clear  in  1  one-cycle pulse; starts a zeroing sweep when idle.
busy  out  1  high while the sweep runs; ports are ignored while high.
en_A  in  1  port A access request.
w_e_A  in  1  port A write when en_A=1, otherwise read.
be_A  in  BE_SIZE  port A byte enables; bit i covers bits [8i+7:8i].
addr_A  in  ADDR_SIZE  port A address.
data_in_A  in  DATA_SIZE  port A write data.
data_out_A  out  DATA_SIZE  port A read data.
valid_A  out  1  data_out_A holds the result of a read.
en_B, w_e_B, be_B, addr_B, data_in_B, data_out_B, valid_B: identical set for port B.

Behaviour:
- Reset state: data_out_A = data_out_B = 0, valid_A = valid_B = 0, sweep address = 0, busy = CLEAR_ON_RESET.
- The array itself is not reset; its contents are undefined until written or swept.
- Read, OUT_REG=0:
  - en=1, w_e=0 sampled at edge N.
  - data_out and valid=1 are visible after edge N+1.
- Read, OUT_REG=1: one extra cycle, so visible after edge N+2.
- valid is high for exactly one cycle per read. It pipelines, so back-to-back reads give continuous valid.
- data_out holds its last value when valid=0.
- Write: en=1, w_e=1 at an edge updates only the bytes with be=1. valid is not asserted for a write.
- Read-during-write, same port: not applicable, since a port does either a read or a write per cycle.
- Cross-port read of an address the other port writes in the same cycle: returns the old word (read-first).
- Write/write collision on the same address in the same cycle:
  - Per byte, port A wins where both enables are set.
  - Bytes enabled by only one port take that port's data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE to CLEAR: on the first edge after nRST releases when CLEAR_ON_RESET=1, or on clear=1 while in IDLE.
  - CLEAR: writes 0 to the sweep address, then increments it, one word per cycle, DEPTH cycles in total.
  - After writing address DEPTH-1: sweep address wraps to 0, FSM returns to IDLE, busy drops at that same edge.
  - busy = 1 in CLEAR, and also during reset when CLEAR_ON_RESET=1.
  - clear asserted while already in CLEAR is ignored; the sweep does not restart.
- While busy:
  - en_A and en_B are ignored: no writes land, and no valid is produced.
  - Reads already in the output pipeline still complete.
- Reset mid-sweep: everything returns to the reset state asynchronously. With CLEAR_ON_RESET=1 the sweep restarts from address 0 after release; with 0, contents stay partially cleared.
- Address arithmetic is modulo DEPTH; there are no out-of-range accesses.

Test Plan:
- Bench config for all scenarios: ADDR_SIZE=4, DATA_SIZE=32.
- CLEAR_ON_RESET=1: release nRST → busy high for exactly 16 cycles, then low. Reading A at addrs 0..15 → all 0, valid one cycle after each request.
- OUT_REG=0: A writes 245 at addr 0, be=4'hF. Next cycle B reads addr 0 → data_out_B=245, valid_B after 1 edge. Repeat with OUT_REG=1 → valid_B after 2 edges.
- Byte enables: word 0x11223344 at addr 3, then A writes 0xAABBCCDD with be=4'b0101 → read gives 0x11BB33DD.
- Write/write collision: A writes 0xAAAAAAAA be=4'b0011 and B writes 0xBBBBBBBB be=4'b0110, both to addr 5 in the same cycle → read gives 0x00BBAAAA (starting from cleared memory).
- Cross-port read-first: addr 2 holds 420; A writes 7 to addr 2 while B reads addr 2 in the same cycle → data_out_B=420; next B read → 7.
- Mid-sweep disruption:
  - Pulse clear, then drop nRST at sweep address 6 → busy=1, valid=0, data_out=0 during reset.
  - After release, busy lasts a full 16 cycles.
  - An A write issued during busy does not land; the later read returns 0.
